sound_comm_mailbox: RTL and testbench

- Controller for the 68000 <-> sound 6502 communication port.
- Queues command bytes written by the 68000 in a small FIFO, and raises a paced NMI to the 6502 while commands are pending.
- Holds a single response latch that the 6502 writes back, with an interrupt to the 68000.
- Drives the SNDBUF/68kBUF status bits read through the coin/self-test port and the SDin68k/SDout68k data paths of the sound board.

---
 rtl/snd_comm_pkg.sv | 19 +
 rtl/snd_cmd_fifo.sv | 77 +++++++
 rtl/sound_comm_mailbox.sv | 153 +++++++++++++++
 tb/tb_sound_comm_mailbox.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/snd_comm_pkg.sv
// Shared types and constants for the 68000 <-> sound 6502 mailbox.
// Holds the NMI sequencer states, the empty-read byte and the occupancy width helper.
package snd_comm_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PULSE    = 2'd1,
    WAIT_ACK = 2'd2,
    HOLDOFF  = 2'd3
  } nmi_state_e;

  localparam logic [7:0] EMPTY_READ = 8'hFF;

  // Occupancy needs one bit more than the pointers so that "full" is representable.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/snd_cmd_fifo.sv
// Command byte FIFO with a registered head byte and a sticky drop flag.
// A pop frees a slot in the same cycle, so push+pop at full is accepted.
module snd_cmd_fifo
  import snd_comm_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CNT_W = cnt_w(DEPTH),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [7:0]       din,
  output logic [7:0]       head,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             empty;
  logic             full;
  logic             pop_ok;
  logic             push_ok;
  logic [CNT_W-1:0] count_nxt;
  logic [7:0]       head_nxt;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_comb begin
    count_nxt = count;
    case ({push_ok, pop_ok})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  // The head register tracks the byte the 6502 will read next, bypassing
  // the array when the incoming byte becomes the head in the same cycle.
  always_comb begin
    head_nxt = head;
    if (count_nxt == '0) begin
      head_nxt = EMPTY_READ;
    end else if (pop_ok) begin
      head_nxt = (count == CNT_W'(1)) ? din : mem[rd_ptr + PTR_W'(1)];
    end else if (push_ok && empty) begin
      head_nxt = din;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      head     <= EMPTY_READ;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nxt;
      head  <= head_nxt;
      if (push && full && !pop_ok) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/sound_comm_mailbox.sv
// 68000 <-> sound 6502 mailbox: command FIFO with paced NMI, response latch with IRQ,
// and the SNDBUF/68kBUF status bits for the coin/self-test port.
module sound_comm_mailbox
  import snd_comm_pkg::*;
#(
  parameter  int CMD_DEPTH   = 4,
  parameter  int NMI_WIDTH   = 2,
  parameter  int NMI_HOLDOFF = 8,
  localparam int CNT_W       = cnt_w(CMD_DEPTH)
) (
  input  logic             SC_2H,
  input  logic             SNDRST_b,
  input  logic [7:0]       m68k_din,
  input  logic             m68k_wr_b,
  input  logic             m68k_rd_b,
  output logic [7:0]       m68k_dout,
  output logic             m68k_irq_b,
  input  logic [7:0]       SDout,
  input  logic             WR68k_b,
  input  logic             RD68k_b,
  output logic [7:0]       SDin68k,
  output logic             SNDNMI_b,
  output logic             ctrl_SNDBUF,
  output logic             ctrl_68kBUF,
  output logic [CNT_W-1:0] cmd_count,
  output logic             cmd_overflow,
  output logic             resp_overrun
);

  localparam int TMR_MAX = (NMI_WIDTH > NMI_HOLDOFF) ? NMI_WIDTH : NMI_HOLDOFF;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  logic m68k_wr_q, m68k_rd_q, wr68k_q, rd68k_q;
  logic push_ev, pop_ev, resp_wr_ev, resp_rd_ev, pop_ok;

  nmi_state_e       state, state_nxt;
  logic [TMR_W-1:0] tmr, tmr_nxt;
  logic             nmi_b_nxt;
  logic             popped, popped_nxt;

  // Strobe history: an event is the first cycle a strobe is seen low.
  always_ff @(posedge SC_2H or negedge SNDRST_b) begin
    if (!SNDRST_b) begin
      m68k_wr_q <= 1'b1;
      m68k_rd_q <= 1'b1;
      wr68k_q   <= 1'b1;
      rd68k_q   <= 1'b1;
    end else begin
      m68k_wr_q <= m68k_wr_b;
      m68k_rd_q <= m68k_rd_b;
      wr68k_q   <= WR68k_b;
      rd68k_q   <= RD68k_b;
    end
  end

  assign push_ev    = m68k_wr_q & ~m68k_wr_b;
  assign pop_ev     = rd68k_q & ~RD68k_b;
  assign resp_wr_ev = wr68k_q & ~WR68k_b;
  assign resp_rd_ev = m68k_rd_q & ~m68k_rd_b;
  assign pop_ok     = pop_ev & (cmd_count != '0);

  snd_cmd_fifo #(.DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk      (SC_2H),
    .rst_n    (SNDRST_b),
    .push     (push_ev),
    .pop      (pop_ev),
    .din      (m68k_din),
    .head     (SDin68k),
    .count    (cmd_count),
    .overflow (cmd_overflow)
  );

  assign ctrl_SNDBUF = (cmd_count != '0);

  // Response latch: a 6502 write beats a coincident 68000 read.
  always_ff @(posedge SC_2H or negedge SNDRST_b) begin
    if (!SNDRST_b) begin
      m68k_dout    <= 8'h00;
      ctrl_68kBUF  <= 1'b0;
      m68k_irq_b   <= 1'b1;
      resp_overrun <= 1'b0;
    end else if (resp_wr_ev) begin
      m68k_dout   <= SDout;
      ctrl_68kBUF <= 1'b1;
      m68k_irq_b  <= 1'b0;
      if (ctrl_68kBUF && !resp_rd_ev) resp_overrun <= 1'b1;
    end else if (resp_rd_ev) begin
      ctrl_68kBUF <= 1'b0;
      m68k_irq_b  <= 1'b1;
    end
  end

  always_ff @(posedge SC_2H or negedge SNDRST_b) begin
    if (!SNDRST_b) begin
      state    <= IDLE;
      tmr      <= '0;
      SNDNMI_b <= 1'b1;
      popped   <= 1'b0;
    end else begin
      state    <= state_nxt;
      tmr      <= tmr_nxt;
      SNDNMI_b <= nmi_b_nxt;
      popped   <= popped_nxt;
    end
  end

  // A pop landing during the pulse is remembered so the pulse still completes
  // before the hold-off starts.
  always_comb begin
    state_nxt  = state;
    tmr_nxt    = tmr;
    nmi_b_nxt  = SNDNMI_b;
    popped_nxt = popped;
    case (state)
      IDLE: begin
        if (cmd_count != '0) begin
          state_nxt  = PULSE;
          nmi_b_nxt  = 1'b0;
          tmr_nxt    = '0;
          popped_nxt = 1'b0;
        end
      end
      PULSE: begin
        if (pop_ok) popped_nxt = 1'b1;
        if (tmr == TMR_W'(NMI_WIDTH - 1)) begin
          nmi_b_nxt = 1'b1;
          tmr_nxt   = '0;
          state_nxt = (popped || pop_ok) ? HOLDOFF : WAIT_ACK;
        end else begin
          tmr_nxt = tmr + TMR_W'(1);
        end
      end
      WAIT_ACK: begin
        if (pop_ok) begin
          state_nxt = HOLDOFF;
          tmr_nxt   = '0;
        end else if (cmd_count == '0) begin
          state_nxt = IDLE;
        end
      end
      HOLDOFF: begin
        if (tmr == TMR_W'(NMI_HOLDOFF - 1)) begin
          state_nxt = IDLE;
          tmr_nxt   = '0;
        end else begin
          tmr_nxt = tmr + TMR_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sound_comm_mailbox.sv
// Directed bench for the sound communication mailbox: FIFO, NMI pacing,
// response latch and asynchronous reset behaviour.
module tb_sound_comm_mailbox;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] m68k_din;
  logic       m68k_wr_b;
  logic       m68k_rd_b;
  logic [7:0] m68k_dout;
  logic       m68k_irq_b;
  logic [7:0] SDout;
  logic       WR68k_b;
  logic       RD68k_b;
  logic [7:0] SDin68k;
  logic       SNDNMI_b;
  logic       ctrl_SNDBUF;
  logic       ctrl_68kBUF;
  logic [2:0] cmd_count;
  logic       cmd_overflow;
  logic       resp_overrun;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  sound_comm_mailbox #(.CMD_DEPTH(4), .NMI_WIDTH(2), .NMI_HOLDOFF(8)) dut (
    .SC_2H        (clk),
    .SNDRST_b     (rst_n),
    .m68k_din     (m68k_din),
    .m68k_wr_b    (m68k_wr_b),
    .m68k_rd_b    (m68k_rd_b),
    .m68k_dout    (m68k_dout),
    .m68k_irq_b   (m68k_irq_b),
    .SDout        (SDout),
    .WR68k_b      (WR68k_b),
    .RD68k_b      (RD68k_b),
    .SDin68k      (SDin68k),
    .SNDNMI_b     (SNDNMI_b),
    .ctrl_SNDBUF  (ctrl_SNDBUF),
    .ctrl_68kBUF  (ctrl_68kBUF),
    .cmd_count    (cmd_count),
    .cmd_overflow (cmd_overflow),
    .resp_overrun (resp_overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic cmd_write(input logic [7:0] b);
    m68k_din  = b;
    m68k_wr_b = 1'b0;
    tick();
    m68k_wr_b = 1'b1;
    tick();
  endtask

  task automatic resp_write(input logic [7:0] b);
    SDout   = b;
    WR68k_b = 1'b0;
    tick();
    WR68k_b = 1'b1;
    tick();
  endtask

  task automatic wait_nmi(input logic level, input int max, input string tag);
    int n = 0;
    while (SNDNMI_b !== level && n < max) begin
      tick();
      n++;
    end
    check(tag, SNDNMI_b, level);
  endtask

  task automatic watch_no_nmi(input int n, input string tag);
    int lows = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (SNDNMI_b !== 1'b1) lows++;
    end
    check(tag, lows, 0);
  endtask

  initial begin
    int p;
    rst_n     = 1'b0;
    m68k_din  = 8'h00;
    m68k_wr_b = 1'b1;
    m68k_rd_b = 1'b1;
    SDout     = 8'h00;
    WR68k_b   = 1'b1;
    RD68k_b   = 1'b1;
    tick();
    check("rst_sdin",   SDin68k, 8'hFF);
    check("rst_dout",   m68k_dout, 8'h00);
    check("rst_irq",    m68k_irq_b, 1);
    check("rst_nmi",    SNDNMI_b, 1);
    check("rst_sndbuf", ctrl_SNDBUF, 0);
    check("rst_68kbuf", ctrl_68kBUF, 0);
    check("rst_count",  cmd_count, 0);
    check("rst_flags",  {cmd_overflow, resp_overrun}, 0);
    rst_n = 1'b1;
    tick();

    // Single command and its NMI pulse
    m68k_din  = 8'h3C;
    m68k_wr_b = 1'b0;
    tick();
    check("w1_count",  cmd_count, 1);
    check("w1_sndbuf", ctrl_SNDBUF, 1);
    check("w1_sdin",   SDin68k, 8'h3C);
    check("w1_nmi_e0", SNDNMI_b, 1);
    m68k_wr_b = 1'b1;
    tick();
    check("w1_nmi_e1", SNDNMI_b, 0);
    tick();
    check("w1_nmi_e2", SNDNMI_b, 0);
    tick();
    check("w1_nmi_e3", SNDNMI_b, 1);
    RD68k_b = 1'b0;
    tick();
    check("p1_count", cmd_count, 0);
    check("p1_sdin",  SDin68k, 8'hFF);
    RD68k_b = 1'b1;
    watch_no_nmi(20, "p1_no_nmi");

    // Overflow and paced pops
    for (int i = 1; i <= 5; i++) cmd_write(8'(i));
    check("ov_count", cmd_count, 4);
    check("ov_flag",  cmd_overflow, 1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("pace_head%0d", i), SDin68k, i + 1);
      RD68k_b = 1'b0;
      tick();
      p = cyc;
      check($sformatf("pace_cnt%0d", i), cmd_count, 3 - i);
      check($sformatf("pace_sdin%0d", i), SDin68k, (i == 3) ? 8'hFF : i + 2);
      RD68k_b = 1'b1;
      if (i < 3) begin
        wait_nmi(1'b0, 30, $sformatf("pace_nmi%0d", i));
        check($sformatf("pace_gap%0d", i), cyc - p, 9);
        wait_nmi(1'b1, 10, $sformatf("pace_rel%0d", i));
      end
    end
    watch_no_nmi(20, "pace_quiet");

    // Push and pop together at full
    do_reset();
    for (int i = 0; i < 4; i++) cmd_write(8'h10 + 8'(i));
    check("pp_full", cmd_count, 4);
    m68k_din  = 8'h14;
    m68k_wr_b = 1'b0;
    RD68k_b   = 1'b0;
    tick();
    check("pp_count", cmd_count, 4);
    check("pp_ovf",   cmd_overflow, 0);
    check("pp_head",  SDin68k, 8'h11);
    m68k_wr_b = 1'b1;
    RD68k_b   = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      RD68k_b = 1'b0;
      tick();
      check($sformatf("pp_drain%0d", i), SDin68k, (i == 3) ? 8'hFF : 8'h12 + i);
      RD68k_b = 1'b1;
      tick();
    end
    check("pp_empty", cmd_count, 0);

    // Response latch
    do_reset();
    SDout   = 8'hA5;
    WR68k_b = 1'b0;
    tick();
    check("r1_dout", m68k_dout, 8'hA5);
    check("r1_buf",  ctrl_68kBUF, 1);
    check("r1_irq",  m68k_irq_b, 0);
    check("r1_ovr",  resp_overrun, 0);
    WR68k_b = 1'b1;
    tick();
    resp_write(8'h5A);
    check("r2_dout", m68k_dout, 8'h5A);
    check("r2_ovr",  resp_overrun, 1);
    m68k_rd_b = 1'b0;
    tick();
    check("r3_irq",  m68k_irq_b, 1);
    check("r3_buf",  ctrl_68kBUF, 0);
    check("r3_dout", m68k_dout, 8'h5A);
    m68k_rd_b = 1'b1;
    tick();
    do_reset();
    resp_write(8'h11);
    SDout     = 8'h22;
    WR68k_b   = 1'b0;
    m68k_rd_b = 1'b0;
    tick();
    check("rs_dout", m68k_dout, 8'h22);
    check("rs_buf",  ctrl_68kBUF, 1);
    check("rs_irq",  m68k_irq_b, 0);
    check("rs_ovr",  resp_overrun, 0);
    WR68k_b   = 1'b1;
    m68k_rd_b = 1'b1;
    tick();

    // Held strobe, then reset during a pulse
    do_reset();
    m68k_din  = 8'h99;
    m68k_wr_b = 1'b0;
    repeat (10) tick();
    check("hold_count", cmd_count, 1);
    check("hold_sdin",  SDin68k, 8'h99);
    m68k_wr_b = 1'b1;
    tick();
    for (int i = 1; i <= 4; i++) cmd_write(8'(i));
    check("hold_ovf", cmd_overflow, 1);
    resp_write(8'h01);
    resp_write(8'h02);
    check("hold_ovr", resp_overrun, 1);
    RD68k_b = 1'b0;
    tick();
    RD68k_b = 1'b1;
    wait_nmi(1'b0, 30, "mid_pulse");
    rst_n = 1'b0;
    #1;
    check("ar_nmi",    SNDNMI_b, 1);
    check("ar_count",  cmd_count, 0);
    check("ar_sndbuf", ctrl_SNDBUF, 0);
    check("ar_sdin",   SDin68k, 8'hFF);
    check("ar_flags",  {cmd_overflow, resp_overrun, ctrl_68kBUF}, 0);
    check("ar_irq",    m68k_irq_b, 1);
    rst_n = 1'b1;
    watch_no_nmi(12, "ar_quiet");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
